// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, FSM state type and parity helper for the PS/2 key decoder.
package ps2_pkg;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EXT    = 3'd1,
      ST_BRK    = 3'd2,
      ST_EXTBRK = 3'd3,
      ST_SKIP   = 3'd4
   } ps2_state_e;
   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;
   localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;
   localparam int KEY_STB = 10;
   localparam int KEY_PRS = 9;
   localparam int KEY_EXT = 8;
   function automatic logic odd_parity_ok(input logic [8:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronizes and filters the PS/2 pins and receives 11-bit frames.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 24000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_o,
   output logic       frame_err_o
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [1:0]    raw;
   logic [1:0]    s1_q, s2_q, filt_q;
   logic [FW-1:0] fcnt_q [2];
   logic          clk_prev_q, fall, din, par_ok, ok;
   logic [3:0]    bit_q, bit_d;
   logic [8:0]    sr_q, sr_d;
   logic [TW-1:0] to_q, to_d;
   logic          valid_d, err_d, valid_q, err_q;
   logic [7:0]    byte_q;
   assign raw = {ps2_data_i, ps2_clk_i};
   // bit 0 is the clock, bit 1 the data; both idle high
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q       <= 2'b11;
         s2_q       <= 2'b11;
         filt_q     <= 2'b11;
         clk_prev_q <= 1'b1;
         for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
      end else begin
         s1_q       <= raw;
         s2_q       <= s1_q;
         clk_prev_q <= filt_q[0];
         for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == filt_q[i]) fcnt_q[i] <= '0;
            else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
               filt_q[i] <= s2_q[i];
               fcnt_q[i] <= '0;
            end else fcnt_q[i] <= fcnt_q[i] + 1'b1;
         end
      end
   end
   assign fall = clk_prev_q & ~filt_q[0];
   assign din  = filt_q[1];
`ifdef PS2_PARITY_CHECK_EN
   assign par_ok = odd_parity_ok(sr_q);
`else
   assign par_ok = 1'b1;
`endif
   assign ok = din & par_ok;
   always_comb begin
      bit_d   = bit_q;
      sr_d    = sr_q;
      to_d    = to_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (fall) begin
         to_d = '0;
         if (bit_q == 4'd0) begin
            bit_d = din ? 4'd0 : 4'd1;
            err_d = din;
         end else if (bit_q == 4'd10) begin
            bit_d   = 4'd0;
            valid_d = ok;
            err_d   = ~ok;
         end else begin
            sr_d  = {din, sr_q[8:1]};
            bit_d = bit_q + 4'd1;
         end
      end else if (bit_q == 4'd0) to_d = '0;
      else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
         bit_d = 4'd0;
         err_d = 1'b1;
         to_d  = '0;
      end else to_d = to_q + 1'b1;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bit_q   <= '0;
         sr_q    <= '0;
         to_q    <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         byte_q  <= '0;
      end else begin
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         to_q    <= to_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         if (valid_d) byte_q <= sr_q[7:0];
      end
   end
   assign byte_valid_o = valid_q;
   assign byte_o       = byte_q;
   assign frame_err_o  = err_q;
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 scancode sequences into the toggle-strobe ps2_key event word.
// Build option PS2_PARITY_CHECK_EN (in ps2_rx_frame) drops frames with bad parity.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 24000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        frame_err
);
   logic       byte_valid;
   logic [7:0] rx_byte;
   ps2_state_e state_q, state_d;
   logic [2:0] skip_q, skip_d;
   logic [10:0] key_q, key_d;
   logic       emit, prs, ext;
   ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk_i       (clk_sys),
      .rst_i       (reset),
      .ps2_clk_i   (ps2_clk),
      .ps2_data_i  (ps2_data),
      .byte_valid_o(byte_valid),
      .byte_o      (rx_byte),
      .frame_err_o (frame_err)
   );
   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      emit    = 1'b0;
      prs     = 1'b1;
      ext     = 1'b0;
      if (byte_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == PS2_EXT) state_d = ST_EXT;
               else if (rx_byte == PS2_BRK) state_d = ST_BRK;
               else if (rx_byte == PS2_PAUSE) begin
                  state_d = ST_SKIP;
                  skip_d  = PS2_PAUSE_SKIP;
               end else emit = 1'b1;
            end
            ST_EXT: begin
               if (rx_byte == PS2_BRK) state_d = ST_EXTBRK;
               else if (rx_byte != PS2_EXT) begin
                  emit    = 1'b1;
                  ext     = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_BRK: begin
               emit    = 1'b1;
               prs     = 1'b0;
               state_d = ST_IDLE;
            end
            ST_EXTBRK: begin
               emit    = 1'b1;
               prs     = 1'b0;
               ext     = 1'b1;
               state_d = ST_IDLE;
            end
            ST_SKIP: begin
               skip_d  = skip_q - 3'd1;
               state_d = (skip_q == 3'd1) ? ST_IDLE : ST_SKIP;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      key_d = emit ? {~key_q[KEY_STB], prs, ext, rx_byte} : key_q;
   end
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= ST_IDLE;
         skip_q  <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         key_q   <= key_d;
      end
   end
   assign ps2_key = key_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: drives PS/2 frames and compares ps2_key/frame_err to an event-level model.
module tb_ps2_key_decoder;
   localparam int FL  = 8;
   localparam int TO  = 24000;
   localparam int H   = 12;
   localparam int GAP = 20;
   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        frame_err;
   int          checks = 0;
   int          errors = 0;
   int          emits = 0;
   int          errs = 0;
   logic        prev_stb = 1'b0;
   logic        exp_stb = 1'b0;
   logic [10:0] exp_key = '0;

   ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .ps2_key  (ps2_key),
      .frame_err(frame_err)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (frame_err === 1'b1) errs <= errs + 1;
      if (ps2_key[10] !== prev_stb) emits <= emits + 1;
      prev_stb <= ps2_key[10];
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         cyc(H);
         ps2_clk = 1'b0;
         cyc(H);
         ps2_clk = 1'b1;
      end
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] b, input logic flip);
      return {1'b1, (~^b) ^ flip, b, 1'b0};
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic flip);
      send_bits(frame_of(b, flip), 11);
      ps2_data = 1'b1;
      cyc(GAP);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      cyc(5);
      reset = 1'b0;
      cyc(3);
      checks++;
      if (ps2_key !== 11'h000) begin
         errors++;
         $display("FAIL reset_key got %h want 000", ps2_key);
      end
      checks++;
      if (frame_err !== 1'b0 || errs !== 0) begin
         errors++;
         $display("FAIL reset_err got %b/%0d want 0/0", frame_err, errs);
      end
   endtask

   task automatic test_space;
      int e0 = emits;
      send_byte(8'h29, 1'b0);
      exp_stb = ~exp_stb;
      exp_key = {exp_stb, 1'b1, 1'b0, 8'h29};
      checks++;
      if (ps2_key !== exp_key || exp_key !== 11'h629) begin
         errors++;
         $display("FAIL space_make got %h want 629", ps2_key);
      end
      send_byte(8'hF0, 1'b0);
      send_byte(8'h29, 1'b0);
      exp_stb = ~exp_stb;
      exp_key = {exp_stb, 1'b0, 1'b0, 8'h29};
      checks++;
      if (ps2_key !== 11'h029) begin
         errors++;
         $display("FAIL space_break got %h want 029", ps2_key);
      end
      checks++;
      if (emits !== e0 + 2) begin
         errors++;
         $display("FAIL space_emits got %0d want %0d", emits - e0, 2);
      end
   endtask

   task automatic test_ext;
      send_byte(8'hE0, 1'b0);
      send_byte(8'h75, 1'b0);
      exp_stb = ~exp_stb;
      exp_key = {exp_stb, 1'b1, 1'b1, 8'h75};
      checks++;
      if (ps2_key !== 11'h775) begin
         errors++;
         $display("FAIL ext_make got %h want 775", ps2_key);
      end
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h75, 1'b0);
      exp_stb = ~exp_stb;
      exp_key = {exp_stb, 1'b0, 1'b1, 8'h75};
      checks++;
      if (ps2_key !== 11'h175) begin
         errors++;
         $display("FAIL ext_break got %h want 175", ps2_key);
      end
   endtask

   task automatic test_parity;
      int r0 = errs;
      send_byte(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      checks++;
      if (errs !== r0 + 1) begin
         errors++;
         $display("FAIL parity_err got %0d want 1", errs - r0);
      end
`else
      exp_stb = ~exp_stb;
      exp_key = {exp_stb, 1'b1, 1'b0, 8'h1C};
      checks++;
      if (errs !== r0) begin
         errors++;
         $display("FAIL parity_err got %0d want 0", errs - r0);
      end
`endif
      checks++;
      if (ps2_key !== exp_key) begin
         errors++;
         $display("FAIL parity_key got %h want %h", ps2_key, exp_key);
      end
   endtask

   task automatic test_timeout;
      int r0 = errs;
      send_bits(frame_of(8'h33, 1'b0), 5);
      ps2_data = 1'b1;
      cyc(TO - 200);
      checks++;
      if (errs !== r0) begin
         errors++;
         $display("FAIL timeout_early got %0d want 0", errs - r0);
      end
      cyc(300);
      checks++;
      if (errs !== r0 + 1) begin
         errors++;
         $display("FAIL timeout_err got %0d want 1", errs - r0);
      end
      send_byte(8'h16, 1'b0);
      exp_stb = ~exp_stb;
      exp_key = {exp_stb, 1'b1, 1'b0, 8'h16};
      checks++;
      if (ps2_key !== exp_key) begin
         errors++;
         $display("FAIL timeout_next got %h want %h", ps2_key, exp_key);
      end
   endtask

   task automatic test_pause;
      logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      int e0 = emits;
      foreach (seq[i]) send_byte(seq[i], 1'b0);
      checks++;
      if (emits !== e0) begin
         errors++;
         $display("FAIL pause_silent got %0d emits want 0", emits - e0);
      end
      send_byte(8'h2E, 1'b0);
      exp_stb = ~exp_stb;
      exp_key = {exp_stb, 1'b1, 1'b0, 8'h2E};
      checks++;
      if (ps2_key !== exp_key || emits !== e0 + 1) begin
         errors++;
         $display("FAIL pause_next got %h/%0d want %h/1", ps2_key, emits - e0, exp_key);
      end
   endtask

   task automatic test_reset_mid;
      int r0;
      send_byte(8'hF0, 1'b0);
      send_bits(frame_of(8'hF0, 1'b0), 5);
      reset = 1'b1;
      cyc(2);
      checks++;
      if (ps2_key !== 11'h000) begin
         errors++;
         $display("FAIL reset_mid_key got %h want 000", ps2_key);
      end
      ps2_data = 1'b1;
      ps2_clk  = 1'b1;
      reset = 1'b0;
      exp_stb = 1'b0;
      cyc(30);
      r0 = errs;
      send_byte(8'h2D, 1'b0);
      exp_stb = ~exp_stb;
      exp_key = {exp_stb, 1'b1, 1'b0, 8'h2D};
      checks++;
      if (ps2_key !== 11'h62D || errs !== r0) begin
         errors++;
         $display("FAIL reset_mid_next got %h/%0d want 62D/0", ps2_key, errs - r0);
      end
   endtask

   task automatic test_glitch;
      int r0 = errs;
      int e0 = emits;
      ps2_clk = 1'b0;
      cyc(FL - 3);
      ps2_clk = 1'b1;
      cyc(30);
      send_byte(8'h1E, 1'b0);
      exp_stb = ~exp_stb;
      exp_key = {exp_stb, 1'b1, 1'b0, 8'h1E};
      checks++;
      if (errs !== r0 || emits !== e0 + 1) begin
         errors++;
         $display("FAIL glitch_fall got err %0d emits %0d want 0/1", errs - r0, emits - e0);
      end
      checks++;
      if (ps2_key !== exp_key) begin
         errors++;
         $display("FAIL glitch_key got %h want %h", ps2_key, exp_key);
      end
   endtask

   // model: pick a key event, encode it as the keyboard would, expect it back
   task automatic test_random;
      for (int n = 0; n < 16; n++) begin
         logic p = 1'($urandom_range(0, 1));
         logic e = 1'($urandom_range(0, 1));
         logic [7:0] c;
         int e0 = emits;
         do c = 8'($urandom_range(1, 255)); while (c == 8'hE0 || c == 8'hE1 || c == 8'hF0);
         if (e) send_byte(8'hE0, 1'b0);
         if (!p) send_byte(8'hF0, 1'b0);
         send_byte(c, 1'b0);
         exp_stb = ~exp_stb;
         exp_key = {exp_stb, p, e, c};
         checks++;
         if (ps2_key !== exp_key || emits !== e0 + 1) begin
            errors++;
            $display("FAIL random_%0d got %h/%0d want %h/1", n, ps2_key, emits - e0, exp_key);
         end
      end
   endtask

   initial begin
      test_reset;
      test_space;
      test_ext;
      test_parity;
      test_timeout;
      test_pause;
      test_reset_mid;
      test_glitch;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
